// File: rtl/tdr_pkg.sv
// rtl/tdr_pkg.sv - shared types and constants for the capture packetizer
package tdr_pkg;

  typedef enum logic [2:0] {
    ST_FILL,
    ST_HDR,
    ST_LEN,
    ST_SEQ,
    ST_DATA,
    ST_CSUM
  } pkt_state_t;

  localparam logic [7:0] DEFAULT_HEADER = 8'hA5;
  localparam int         CSUM_W         = 8;

endpackage

// File: rtl/tdr_sample_buffer.sv
// rtl/tdr_sample_buffer.sv - simple dual-port sample RAM, one write and one registered read port
module tdr_sample_buffer #(
  parameter int DEPTH = 32,
  parameter int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic          clk,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic [7:0]    wr_data,
  input  logic [AW-1:0] rd_addr,
  output logic [7:0]    rd_data
);

  logic [7:0] mem [DEPTH];

  // Synchronous write and synchronous read; a same-edge collision returns the old word.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
    rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/tdr_packetizer.sv
// rtl/tdr_packetizer.sv - buffers capture samples and streams framed packets to the UART
module tdr_packetizer
  import tdr_pkg::*;
#(
  parameter int         DEPTH  = 32,
  parameter logic [7:0] HEADER = DEFAULT_HEADER
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] sample_in,
  input  logic       sample_valid,
  input  logic       flush,
  output logic [7:0] tx_data,
  output logic       tx_valid,
  input  logic       tx_ready,
  output logic       busy,
  output logic       overflow
);

  localparam int         AW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [8:0] DEPTH_W = 9'(DEPTH);

  pkt_state_t        state, state_n;
  logic [7:0]        count, count_n;
  logic [7:0]        seq, seq_n;
  logic [7:0]        rd_ptr, rd_ptr_n;
  logic [7:0]        tx_data_n;
  logic              tx_valid_n;
  logic              overflow_n;
  logic [CSUM_W-1:0] csum, csum_n;
  logic [CSUM_W-1:0] sum_data;
  logic [7:0]        rd_data;
  logic [8:0]        fill_count;
  logic              xfer;
  logic              wr_en;

  assign xfer       = tx_valid && tx_ready;
  assign wr_en      = (state == ST_FILL) && sample_valid;
  assign fill_count = {1'b0, count} + {8'd0, sample_valid};
  assign busy       = (state != ST_FILL);
  assign sum_data   = csum + tx_data;

  // rd_ptr tracks the word held in rd_data; the RAM is addressed with its next value
  // so the following data byte is already read when the current one is accepted.
  tdr_sample_buffer #(.DEPTH(DEPTH), .AW(AW)) u_buf (
    .clk     (clk),
    .wr_en   (wr_en),
    .wr_addr (count[AW-1:0]),
    .wr_data (sample_in),
    .rd_addr (rd_ptr_n[AW-1:0]),
    .rd_data (rd_data)
  );

  // Next-state, next output byte and checksum accumulation for each packet field.
  always_comb begin
    state_n    = state;
    count_n    = count;
    seq_n      = seq;
    rd_ptr_n   = rd_ptr;
    csum_n     = csum;
    tx_data_n  = tx_data;
    tx_valid_n = tx_valid;
    overflow_n = overflow | (sample_valid && (state != ST_FILL));
    case (state)
      ST_FILL: begin
        count_n  = fill_count[7:0];
        rd_ptr_n = 8'd0;
        if ((fill_count == DEPTH_W) || (flush && (fill_count != 9'd0))) begin
          state_n    = ST_HDR;
          tx_valid_n = 1'b1;
          tx_data_n  = HEADER;
          csum_n     = fill_count[7:0];
        end
      end
      ST_HDR: begin
        if (xfer) begin
          state_n   = ST_LEN;
          tx_data_n = count;
        end
      end
      ST_LEN: begin
        if (xfer) begin
          state_n   = ST_SEQ;
          tx_data_n = seq;
          csum_n    = csum + seq;
        end
      end
      ST_SEQ: begin
        if (xfer) begin
          state_n   = ST_DATA;
          tx_data_n = rd_data;
          rd_ptr_n  = rd_ptr + 8'd1;
        end
      end
      ST_DATA: begin
        if (xfer) begin
          csum_n = sum_data;
          if (rd_ptr == count) begin
            state_n   = ST_CSUM;
            tx_data_n = sum_data;
          end else begin
            tx_data_n = rd_data;
            rd_ptr_n  = rd_ptr + 8'd1;
          end
        end
      end
      ST_CSUM: begin
        if (xfer) begin
          state_n    = ST_FILL;
          tx_valid_n = 1'b0;
          tx_data_n  = 8'd0;
          seq_n      = seq + 8'd1;
          count_n    = 8'd0;
        end
      end
      default: state_n = ST_FILL;
    endcase
  end

  // State register; reset aborts any packet in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_FILL;
    end else begin
      state <= state_n;
    end
  end

  // Datapath and registered output byte.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count    <= 8'd0;
      seq      <= 8'd0;
      rd_ptr   <= 8'd0;
      csum     <= '0;
      tx_data  <= 8'd0;
      tx_valid <= 1'b0;
      overflow <= 1'b0;
    end else begin
      count    <= count_n;
      seq      <= seq_n;
      rd_ptr   <= rd_ptr_n;
      csum     <= csum_n;
      tx_data  <= tx_data_n;
      tx_valid <= tx_valid_n;
      overflow <= overflow_n;
    end
  end

endmodule

// File: tb/tb_tdr_packetizer.sv
// tb/tb_tdr_packetizer.sv - table-driven self-checking bench for tdr_packetizer at DEPTH=4
module tb_tdr_packetizer;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] sample_in;
  logic       sample_valid;
  logic       flush;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;
  logic       busy;
  logic       overflow;

  int checks = 0;
  int errors = 0;

  typedef struct {
    string       name;
    logic [31:0] samples;
    int          ns;
    bit          flush_same;
    bit          flush_after;
    logic [63:0] exp;
    int          ne;
  } vec_t;

  vec_t        vecs [5];
  int          bp_pat [6];
  logic [63:0] e;
  logic [7:0]  s, d;
  int          idx, cyc;
  bit          hs;

  tdr_packetizer #(.DEPTH(4), .HEADER(8'hA5)) dut (
    .clk          (clk),
    .rst          (rst),
    .sample_in    (sample_in),
    .sample_valid (sample_valid),
    .flush        (flush),
    .tx_data      (tx_data),
    .tx_valid     (tx_valid),
    .tx_ready     (tx_ready),
    .busy         (busy),
    .overflow     (overflow)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check8(input string name, input logic [7:0] act, input logic [7:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %02h expected %02h", name, act, req);
    end
  endtask

  task automatic check1(input string name, input logic act, input logic req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0b expected %0b", name, act, req);
    end
  endtask

  task automatic send_record(input logic [31:0] smp, input int ns, input bit fs, input bit fa);
    for (int i = 0; i < ns; i++) begin
      sample_in    = smp[31-8*i -: 8];
      sample_valid = 1'b1;
      flush        = fs && (i == ns - 1);
      tick();
    end
    sample_valid = 1'b0;
    flush        = 1'b0;
    sample_in    = 8'd0;
    if (fa) begin
      flush = 1'b1;
      tick();
      flush = 1'b0;
    end
  endtask

  task automatic expect_packet(input string name, input logic [63:0] ex, input int ne, input int inject_at);
    tx_ready = 1'b1;
    for (int k = 0; k < ne; k++) begin
      check1($sformatf("%s valid%0d", name, k), tx_valid, 1'b1);
      check8($sformatf("%s byte%0d", name, k), tx_data, ex[63-8*k -: 8]);
      if (k == inject_at) begin
        sample_in    = 8'h55;
        sample_valid = 1'b1;
      end
      tick();
      sample_valid = 1'b0;
      sample_in    = 8'd0;
    end
    check1($sformatf("%s gap valid", name), tx_valid, 1'b0);
    check1($sformatf("%s gap busy", name), busy, 1'b0);
  endtask

  initial begin
    vecs[0] = '{"full",    32'h10203040, 4, 1'b0, 1'b0,
                {8'hA5, 8'h04, 8'h00, 8'h10, 8'h20, 8'h30, 8'h40, 8'hA4}, 8};
    vecs[1] = '{"flush",   {8'h01, 8'h02, 16'h0}, 2, 1'b0, 1'b1,
                {8'hA5, 8'h02, 8'h01, 8'h01, 8'h02, 8'h06, 16'h0}, 6};
    vecs[2] = '{"simul",   {8'h07, 24'h0}, 1, 1'b1, 1'b0,
                {8'hA5, 8'h01, 8'h02, 8'h07, 8'h0A, 24'h0}, 5};
    vecs[3] = '{"carry",   32'hFFFFFF01, 4, 1'b0, 1'b0,
                {8'hA5, 8'h04, 8'h03, 8'hFF, 8'hFF, 8'hFF, 8'h01, 8'h05}, 8};
    vecs[4] = '{"simul3",  {8'h80, 8'h81, 8'h82, 8'h00}, 3, 1'b1, 1'b0,
                {8'hA5, 8'h03, 8'h04, 8'h80, 8'h81, 8'h82, 8'h8A, 8'h00}, 7};
    bp_pat = '{1, 0, 0, 1, 0, 1};

    rst          = 1'b1;
    sample_in    = 8'd0;
    sample_valid = 1'b0;
    flush        = 1'b0;
    tx_ready     = 1'b0;
    tick();
    tick();
    check8("reset tx_data", tx_data, 8'd0);
    check1("reset tx_valid", tx_valid, 1'b0);
    check1("reset busy", busy, 1'b0);
    check1("reset overflow", overflow, 1'b0);
    rst = 1'b0;
    tick();
    check1("post reset tx_valid", tx_valid, 1'b0);

    flush = 1'b1;
    tick();
    flush = 1'b0;
    for (int i = 0; i < 3; i++) begin
      check1($sformatf("empty flush valid%0d", i), tx_valid, 1'b0);
      check1($sformatf("empty flush busy%0d", i), busy, 1'b0);
      tick();
    end

    for (int v = 0; v < 5; v++) begin
      send_record(vecs[v].samples, vecs[v].ns, vecs[v].flush_same, vecs[v].flush_after);
      expect_packet(vecs[v].name, vecs[v].exp, vecs[v].ne, -1);
    end

    send_record(32'h10203040, 4, 1'b0, 1'b0);
    e   = {8'hA5, 8'h04, 8'h05, 8'h10, 8'h20, 8'h30, 8'h40, 8'hA9};
    idx = 0;
    cyc = 0;
    while (idx < 8 && cyc < 100) begin
      tx_ready = bp_pat[cyc % 6] != 0;
      check1($sformatf("bp valid c%0d", cyc), tx_valid, 1'b1);
      check8($sformatf("bp byte%0d c%0d", idx, cyc), tx_data, e[63-8*idx -: 8]);
      hs = tx_ready && tx_valid;
      tick();
      if (hs) idx++;
      cyc++;
    end
    checks++;
    if (idx != 8) begin
      errors++;
      $display("FAIL bp timeout: got %0d bytes expected 8", idx);
    end
    tx_ready = 1'b1;
    check1("bp gap valid", tx_valid, 1'b0);

    check1("ovf before", overflow, 1'b0);
    send_record(32'h11223344, 4, 1'b0, 1'b0);
    expect_packet("ovf pkt", {8'hA5, 8'h04, 8'h06, 8'h11, 8'h22, 8'h33, 8'h44, 8'hB4}, 8, 4);
    check1("ovf set", overflow, 1'b1);
    send_record({8'h66, 24'h0}, 1, 1'b1, 1'b0);
    expect_packet("ovf next", {8'hA5, 8'h01, 8'h07, 8'h66, 8'h6E, 24'h0}, 5, -1);
    check1("ovf sticky", overflow, 1'b1);

    send_record(32'h01020304, 4, 1'b0, 1'b0);
    e = {8'hA5, 8'h04, 8'h08, 8'h01, 32'h0};
    for (int k = 0; k < 4; k++) begin
      check8($sformatf("rst pkt byte%0d", k), tx_data, e[63-8*k -: 8]);
      if (k < 3) tick();
    end
    #2;
    rst = 1'b1;
    #1;
    check8("mid rst tx_data", tx_data, 8'd0);
    check1("mid rst tx_valid", tx_valid, 1'b0);
    check1("mid rst busy", busy, 1'b0);
    check1("mid rst overflow", overflow, 1'b0);
    tick();
    rst = 1'b0;
    tick();
    check1("after rst idle", tx_valid, 1'b0);
    send_record({8'h09, 24'h0}, 1, 1'b1, 1'b0);
    expect_packet("after rst", {8'hA5, 8'h01, 8'h00, 8'h09, 8'h0A, 24'h0}, 5, -1);

    for (int r = 0; r < 256; r++) begin
      s = 8'(r + 1);
      d = 8'(r) ^ 8'h5A;
      send_record({d, 24'h0}, 1, 1'b1, 1'b0);
      expect_packet($sformatf("wrap r%0d", r), {8'hA5, 8'h01, s, d, 8'(8'h01 + s + d), 24'h0}, 5, -1);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
